// File: rtl/pipe_front_regs.sv
// Pipeline front end: fetch PC register, IF/ID register and ID/EX register,
// with hazard-unit control (stall/flush/redirect) and saturating stall/flush
// performance counters. All outputs except PCPlus4F come straight from flops.
module pipe_front_regs #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  // hazard control
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        FlushE,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  // fetch
  input  logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  // IF/ID
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  // ID/EX inputs from decode
  input  logic        RegWriteD,
  input  logic [1:0]  ResultSrcD,
  input  logic        MemWriteD,
  input  logic        JumpD,
  input  logic        BranchD,
  input  logic [2:0]  ALUControlD,
  input  logic        ALUSrcD,
  input  logic [31:0] RD1D,
  input  logic [31:0] RD2D,
  input  logic [31:0] ImmExtD,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  RdD,
  // ID/EX outputs to execute
  output logic        RegWriteE,
  output logic [1:0]  ResultSrcE,
  output logic        MemWriteE,
  output logic        JumpE,
  output logic        BranchE,
  output logic [2:0]  ALUControlE,
  output logic        ALUSrcE,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E,
  output logic [31:0] ImmExtE,
  output logic [31:0] PCE,
  output logic [31:0] PCPlus4E,
  output logic [4:0]  Rs1E,
  output logic [4:0]  Rs2E,
  output logic [4:0]  RdE,
  output logic        ValidE,
  // performance counters
  output logic [15:0] StallCount,
  output logic [15:0] FlushCount
);

  // Everything the ID/EX register carries, so flush/load act on one word.
  typedef struct packed {
    logic        regWrite;
    logic [1:0]  resultSrc;
    logic        memWrite;
    logic        jump;
    logic        branch;
    logic [2:0]  aluControl;
    logic        aluSrc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] immExt;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        valid;
  } idExT;

  // Counter step that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] satInc16(input logic [15:0] value, input logic enable);
    logic [15:0] result;
    if (enable && (value != 16'hFFFF)) begin
      result = value + 16'd1;
    end else begin
      result = value;
    end
    return result;
  endfunction

  logic [31:0] pcNext_s;
  logic [31:0] instrDNext_s;
  logic [31:0] pcDNext_s;
  logic [31:0] pcPlus4DNext_s;
  logic        validDNext_s;
  idExT        idExLoad_s;
  idExT        idExNext_s;
  idExT        idEx_r;
  logic [15:0] stallCountNext_s;
  logic [15:0] flushCountNext_s;

  // Sequential adder; wraps modulo 2^32 so 32'hFFFF_FFFC steps to zero.
  assign PCPlus4F = PCF + 32'd4;

  // Next fetch PC: a redirect from Execute always wins so a taken branch is never lost.
  always_comb begin
    pcNext_s = PCF;
    if (PCSrcE) begin
      pcNext_s = PCTargetE;
    end else if (StallF) begin
      pcNext_s = PCF;
    end else begin
      pcNext_s = PCPlus4F;
    end
  end

  // IF/ID next state: flush inserts a bubble even if Decode is also stalled.
  always_comb begin
    instrDNext_s   = InstrD;
    pcDNext_s      = PCD;
    pcPlus4DNext_s = PCPlus4D;
    validDNext_s   = ValidD;
    if (FlushD) begin
      instrDNext_s   = NOP_INSTR;
      pcDNext_s      = 32'h0000_0000;
      pcPlus4DNext_s = 32'h0000_0000;
      validDNext_s   = 1'b0;
    end else if (StallD) begin
      instrDNext_s   = InstrD;
      pcDNext_s      = PCD;
      pcPlus4DNext_s = PCPlus4D;
      validDNext_s   = ValidD;
    end else begin
      instrDNext_s   = InstrF;
      pcDNext_s      = PCF;
      pcPlus4DNext_s = PCPlus4F;
      validDNext_s   = 1'b1;
    end
  end

  // Gather the Decode-side values; PC and PC+4 come from the IF/ID register itself.
  always_comb begin
    idExLoad_s            = '0;
    idExLoad_s.regWrite   = RegWriteD;
    idExLoad_s.resultSrc  = ResultSrcD;
    idExLoad_s.memWrite   = MemWriteD;
    idExLoad_s.jump       = JumpD;
    idExLoad_s.branch     = BranchD;
    idExLoad_s.aluControl = ALUControlD;
    idExLoad_s.aluSrc     = ALUSrcD;
    idExLoad_s.rd1        = RD1D;
    idExLoad_s.rd2        = RD2D;
    idExLoad_s.immExt     = ImmExtD;
    idExLoad_s.pc         = PCD;
    idExLoad_s.pcPlus4    = PCPlus4D;
    idExLoad_s.rs1        = Rs1D;
    idExLoad_s.rs2        = Rs2D;
    idExLoad_s.rd         = RdD;
    idExLoad_s.valid      = ValidD;
  end

  // ID/EX next state: no stall here; a flush zeroes every field so the bubble
  // carries RegWrite=0 and MemWrite=0 and cannot touch architectural state.
  always_comb begin
    idExNext_s = '0;
    if (FlushE) begin
      idExNext_s = '0;
    end else begin
      idExNext_s = idExLoad_s;
    end
  end

  // Counter next values: a stall overridden by a flush of Decode is not a stall.
  always_comb begin
    stallCountNext_s = satInc16(StallCount, StallD && !FlushD);
    flushCountNext_s = satInc16(FlushCount, FlushE);
  end

  // State registers; reset takes effect immediately and discards any pending stall or flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PCF        <= RESET_PC;
      InstrD     <= NOP_INSTR;
      PCD        <= 32'h0000_0000;
      PCPlus4D   <= 32'h0000_0000;
      ValidD     <= 1'b0;
      idEx_r     <= '0;
      StallCount <= 16'h0000;
      FlushCount <= 16'h0000;
    end else begin
      PCF        <= pcNext_s;
      InstrD     <= instrDNext_s;
      PCD        <= pcDNext_s;
      PCPlus4D   <= pcPlus4DNext_s;
      ValidD     <= validDNext_s;
      idEx_r     <= idExNext_s;
      StallCount <= stallCountNext_s;
      FlushCount <= flushCountNext_s;
    end
  end

  assign RegWriteE   = idEx_r.regWrite;
  assign ResultSrcE  = idEx_r.resultSrc;
  assign MemWriteE   = idEx_r.memWrite;
  assign JumpE       = idEx_r.jump;
  assign BranchE     = idEx_r.branch;
  assign ALUControlE = idEx_r.aluControl;
  assign ALUSrcE     = idEx_r.aluSrc;
  assign RD1E        = idEx_r.rd1;
  assign RD2E        = idEx_r.rd2;
  assign ImmExtE     = idEx_r.immExt;
  assign PCE         = idEx_r.pc;
  assign PCPlus4E    = idEx_r.pcPlus4;
  assign Rs1E        = idEx_r.rs1;
  assign Rs2E        = idEx_r.rs2;
  assign RdE         = idEx_r.rd;
  assign ValidE      = idEx_r.valid;

  pipe_front_regs_chk uChk (
    .clk       (clk),
    .reset     (reset),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .FlushE    (FlushE),
    .PCF       (PCF),
    .PCPlus4F  (PCPlus4F),
    .RegWriteE (RegWriteE),
    .MemWriteE (MemWriteE),
    .ValidE    (ValidE)
  );

endmodule

// Runtime checks on the front-end registers: observed between clock edges,
// cleared by reset so a reset pulse never leaves a stale expectation behind.
module pipe_front_regs_chk (
  input logic        clk,
  input logic        reset,
  input logic        PCSrcE,
  input logic [31:0] PCTargetE,
  input logic        FlushE,
  input logic [31:0] PCF,
  input logic [31:0] PCPlus4F,
  input logic        RegWriteE,
  input logic        MemWriteE,
  input logic        ValidE
);

  logic        redirectSeen_r;
  logic [31:0] redirectTarget_r;
  logic        flushSeen_r;

  // Remember what the last edge asked for so the result can be checked afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      redirectSeen_r   <= 1'b0;
      redirectTarget_r <= 32'h0000_0000;
      flushSeen_r      <= 1'b0;
    end else begin
      redirectSeen_r   <= PCSrcE;
      redirectTarget_r <= PCTargetE;
      flushSeen_r      <= FlushE;
    end
  end

  // Mid-cycle checks: redirect taken, flushed bubble inert, PC+4 consistent.
  always @(negedge clk) begin
    if (!reset) begin
      aPcPlus4: assert (PCPlus4F == PCF + 32'd4);
      if (redirectSeen_r) begin
        aRedirect: assert (PCF == redirectTarget_r);
      end
      if (flushSeen_r) begin
        aBubble: assert (!RegWriteE && !MemWriteE && !ValidE);
      end
    end
  end

endmodule

// File: tb/tb_pipe_front_regs.sv
// Directed bench for pipe_front_regs: free-running fetch with a scoreboard for
// IF/ID and ID/EX contents, then load-use, branch, priority, wrap, saturation
// and asynchronous reset scenarios.
module tb_pipe_front_regs;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] I0  = 32'h0050_0093;
  localparam logic [31:0] I1  = 32'h00A0_0113;
  localparam logic [31:0] I2  = 32'h00F0_0193;

  logic        clk;
  logic        reset;
  logic        StallF, StallD, FlushD, FlushE, PCSrcE;
  logic [31:0] PCTargetE, InstrF;
  logic [31:0] PCF, PCPlus4F, InstrD, PCD, PCPlus4D;
  logic        ValidD;
  logic        RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
  logic [1:0]  ResultSrcD;
  logic [2:0]  ALUControlD;
  logic [31:0] RD1D, RD2D, ImmExtD;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ValidE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic [15:0] StallCount, FlushCount;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct { logic [31:0] instr; logic [31:0] pc; } dExpT;
  typedef struct { logic [31:0] rd1;   logic [31:0] pc; } eExpT;
  dExpT dQ[$];
  eExpT eQ[$];
  logic [31:0] pcModel;
  logic [31:0] pcdModel;

  pipe_front_regs dut (
    .clk(clk), .reset(reset),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
    .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD),
    .JumpD(JumpD), .BranchD(BranchD), .ALUControlD(ALUControlD), .ALUSrcD(ALUSrcD),
    .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .BranchE(BranchE), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ValidE(ValidE),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    assertCount++;
    assert (obs === expv) else begin
      failCount++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One unstalled cycle: expectations are queued as the stimulus is applied
  // and retired once the edge has moved them into IF/ID and ID/EX.
  task automatic runStep(input logic [31:0] instr, input logic [31:0] rd1);
    dExpT d;
    eExpT e;
    InstrF = instr;
    RD1D   = rd1;
    d.instr = instr;  d.pc = pcModel;  dQ.push_back(d);
    e.rd1   = rd1;    e.pc = pcdModel; eQ.push_back(e);
    tick();
    d = dQ.pop_front();
    e = eQ.pop_front();
    check("sb_InstrD", InstrD, d.instr);
    check("sb_PCD",    PCD,    d.pc);
    check("sb_RD1E",   RD1E,   e.rd1);
    check("sb_PCE",    PCE,    e.pc);
    pcdModel = d.pc;
    pcModel  = pcModel + 32'd4;
  endtask

  initial begin
    reset = 1'b0;
    StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; FlushE = 1'b0; PCSrcE = 1'b0;
    PCTargetE = 32'h0; InstrF = 32'h0;
    RegWriteD = 1'b1; ResultSrcD = 2'b01; MemWriteD = 1'b0; JumpD = 1'b1; BranchD = 1'b1;
    ALUControlD = 3'b101; ALUSrcD = 1'b1; RD1D = 32'h0; RD2D = 32'hDEAD_0002;
    ImmExtD = 32'h0000_0005; Rs1D = 5'd3; Rs2D = 5'd4; RdD = 5'd1;
    pcModel = 32'h0; pcdModel = 32'h0;

    // Reset applied before any clock edge.
    #1 reset = 1'b1;
    #1;
    check("rst_PCF",        PCF,                32'h0);
    check("rst_PCPlus4F",   PCPlus4F,           32'h4);
    check("rst_InstrD",     InstrD,             NOP);
    check("rst_ValidD",     32'(ValidD),        32'h0);
    check("rst_ValidE",     32'(ValidE),        32'h0);
    check("rst_RegWriteE",  32'(RegWriteE),     32'h0);
    check("rst_StallCount", 32'(StallCount),    32'h0);
    check("rst_FlushCount", 32'(FlushCount),    32'h0);

    @(posedge clk);
    #1 reset = 1'b0;

    // Free-running fetch.
    runStep(I0, 32'h0000_0011);
    check("run1_PCF",      PCF,            32'h4);
    check("run1_PCPlus4F", PCPlus4F,       32'h8);
    check("run1_PCPlus4D", PCPlus4D,       32'h4);
    check("run1_ValidD",   32'(ValidD),    32'h1);
    check("run1_ValidE",   32'(ValidE),    32'h0);
    runStep(I1, 32'h0000_0022);
    check("run2_PCF",      PCF,            32'h8);
    check("run2_ValidE",   32'(ValidE),    32'h1);
    check("run2_RegWriteE",32'(RegWriteE), 32'h1);

    // Load-use: stall fetch and decode, bubble into execute.
    InstrF = I2; RD1D = 32'h0000_0033; MemWriteD = 1'b1;
    StallF = 1'b1; StallD = 1'b1; FlushE = 1'b1;
    tick();
    check("lu_PCF",        PCF,                32'h8);
    check("lu_InstrD",     InstrD,             I1);
    check("lu_PCD",        PCD,                32'h4);
    check("lu_ValidD",     32'(ValidD),        32'h1);
    check("lu_ValidE",     32'(ValidE),        32'h0);
    check("lu_RegWriteE",  32'(RegWriteE),     32'h0);
    check("lu_MemWriteE",  32'(MemWriteE),     32'h0);
    check("lu_ResultSrcE", 32'(ResultSrcE),    32'h0);
    check("lu_JumpE",      32'(JumpE),         32'h0);
    check("lu_BranchE",    32'(BranchE),       32'h0);
    check("lu_ALUCtrlE",   32'(ALUControlE),   32'h0);
    check("lu_ALUSrcE",    32'(ALUSrcE),       32'h0);
    check("lu_RD1E",       RD1E,               32'h0);
    check("lu_RD2E",       RD2E,               32'h0);
    check("lu_ImmExtE",    ImmExtE,            32'h0);
    check("lu_PCE",        PCE,                32'h0);
    check("lu_PCPlus4E",   PCPlus4E,           32'h0);
    check("lu_Rs1E",       32'(Rs1E),          32'h0);
    check("lu_Rs2E",       32'(Rs2E),          32'h0);
    check("lu_RdE",        32'(RdE),           32'h0);
    check("lu_StallCount", 32'(StallCount),    32'h1);
    check("lu_FlushCount", 32'(FlushCount),    32'h1);
    StallF = 1'b0; StallD = 1'b0; FlushE = 1'b0; MemWriteD = 1'b0;

    runStep(I2, 32'h0000_0044);
    check("run3_PCF",    PCF,         32'hC);
    check("run3_ValidE", 32'(ValidE), 32'h1);

    // Taken branch: redirect and flush both stages.
    PCSrcE = 1'b1; PCTargetE = 32'h0000_0100; FlushD = 1'b1; FlushE = 1'b1; MemWriteD = 1'b1;
    tick();
    check("br_PCF",        PCF,             32'h100);
    check("br_InstrD",     InstrD,          NOP);
    check("br_PCD",        PCD,             32'h0);
    check("br_ValidD",     32'(ValidD),     32'h0);
    check("br_ValidE",     32'(ValidE),     32'h0);
    check("br_RegWriteE",  32'(RegWriteE),  32'h0);
    check("br_MemWriteE",  32'(MemWriteE),  32'h0);
    check("br_FlushCount", 32'(FlushCount), 32'h2);
    check("br_StallCount", 32'(StallCount), 32'h1);

    // Redirect beats StallF, FlushD beats StallD, no stall counted.
    StallF = 1'b1; StallD = 1'b1; FlushD = 1'b1; FlushE = 1'b0; PCTargetE = 32'h0000_0040;
    tick();
    check("pri_PCF",        PCF,             32'h40);
    check("pri_InstrD",     InstrD,          NOP);
    check("pri_ValidD",     32'(ValidD),     32'h0);
    check("pri_StallCount", 32'(StallCount), 32'h1);
    check("pri_FlushCount", 32'(FlushCount), 32'h2);
    check("pri_RegWriteE",  32'(RegWriteE),  32'h1);
    StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; MemWriteD = 1'b0;

    // PC wrap at the top of the address space.
    PCTargetE = 32'hFFFF_FFFC; InstrF = I0;
    tick();
    check("wrap_PCF",      PCF,         32'hFFFF_FFFC);
    check("wrap_PCPlus4F", PCPlus4F,    32'h0);
    check("wrap_InstrD",   InstrD,      I0);
    check("wrap_PCD",      PCD,         32'h40);
    PCSrcE = 1'b0;
    tick();
    check("wrap2_PCF",      PCF,         32'h0);
    check("wrap2_PCD",      PCD,         32'hFFFF_FFFC);
    check("wrap2_PCPlus4D", PCPlus4D,    32'h0);

    // Stall counter saturation (starting from 1).
    StallF = 1'b1; StallD = 1'b1;
    repeat (65533) @(posedge clk);
    #1;
    check("sat_near",   32'(StallCount), 32'hFFFE);
    repeat (3) @(posedge clk);
    #1;
    check("sat_hold",   32'(StallCount), 32'hFFFF);
    check("sat_flush",  32'(FlushCount), 32'h2);
    check("sat_PCF",    PCF,             32'h0);

    // Asynchronous reset pulse between edges during a stall.
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("ar_PCF",        PCF,             32'h0);
    check("ar_InstrD",     InstrD,          NOP);
    check("ar_PCD",        PCD,             32'h0);
    check("ar_ValidD",     32'(ValidD),     32'h0);
    check("ar_ValidE",     32'(ValidE),     32'h0);
    check("ar_RD1E",       RD1E,            32'h0);
    check("ar_StallCount", 32'(StallCount), 32'h0);
    check("ar_FlushCount", 32'(FlushCount), 32'h0);
    InstrF = I2;
    tick();
    check("arh_PCF",        PCF,             32'h0);
    check("arh_InstrD",     InstrD,          NOP);
    check("arh_StallCount", 32'(StallCount), 32'h0);
    reset = 1'b0; StallF = 1'b0; StallD = 1'b0; InstrF = I1;
    tick();
    check("post_PCF",        PCF,             32'h4);
    check("post_InstrD",     InstrD,          I1);
    check("post_ValidD",     32'(ValidD),     32'h1);
    check("post_StallCount", 32'(StallCount), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
